// File: rtl/softmax_stim_seq_pkg.sv
// Shared types and constants for the softmax stimulus sequencer.
package softmax_stim_seq_pkg;

  localparam int Q88_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Address width for a store of 'depth' entries, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/softmax_stim_seq_if.sv
// Control, vector-load and output stream signals of the stimulus sequencer.
interface softmax_stim_seq_if
  import softmax_stim_seq_pkg::*;
#(
  parameter int N     = 64,
  parameter int W     = Q88_W,
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
);
  localparam int AW = addr_w(DEPTH);

  logic             start;
  logic             stop;
  logic             mode_loop;
  logic [AW-1:0]    last_idx;
  logic [GAP_W-1:0] gap;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [N*W-1:0]   wr_data;
  logic             out_ready;
  logic             out_valid;
  logic [N*W-1:0]   out_x_flat;
  logic [AW-1:0]    out_idx;
  logic             out_last;
  logic             en;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, mode_loop, last_idx, gap, wr_en, wr_addr, wr_data, out_ready,
    input  out_valid, out_x_flat, out_idx, out_last, en, busy, done
  );

  modport slave (
    input  start, stop, mode_loop, last_idx, gap, wr_en, wr_addr, wr_data, out_ready,
    output out_valid, out_x_flat, out_idx, out_last, en, busy, done
  );

endinterface

// File: rtl/softmax_stim_seq_vec_store.sv
// DEPTH x N*W vector register file: one synchronous write port, one combinational read port.
module softmax_stim_seq_vec_store #(
  parameter int N     = 64,
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [N*W-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [N*W-1:0] rdata
);

  logic [N*W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; they survive rst so a loaded set can be replayed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/softmax_stim_seq.sv
// Stimulus sequencer: plays stored Q8.8 vectors over valid/ready with optional looping,
// inter-vector idle gaps, abort, and runtime loading of the vector store.
module softmax_stim_seq
  import softmax_stim_seq_pkg::*;
#(
  parameter int N     = 64,
  parameter int W     = Q88_W,
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input logic             clk,
  input logic             rst,
  softmax_stim_seq_if.slave bus
);

  localparam int            AW      = addr_w(DEPTH);
  localparam logic [AW-1:0] MAX_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [AW-1:0]    last_q, last_d;
  logic             loop_q, loop_d;

  logic             out_valid_q, out_valid_d;
  logic [N*W-1:0]   out_x_q, out_x_d;
  logic [AW-1:0]    out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             en_q, en_d;
  logic             done_q, done_d;

  logic             hs;
  logic             wr_ok;
  logic [AW-1:0]    last_clamped;
  logic [N*W-1:0]   rd_data;

  softmax_stim_seq_vec_store #(
    .N     (N),
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (idx_d),
    .rdata (rd_data)
  );

  always_comb begin
    last_clamped = (bus.last_idx > MAX_IDX) ? MAX_IDX : bus.last_idx;
    hs           = out_valid_q & bus.out_ready;
    wr_ok        = bus.wr_en & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    state_d   = state_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    last_d    = last_q;
    loop_d    = loop_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d   = ST_SEND;
          idx_d     = '0;
          loop_d    = bus.mode_loop;
          last_d    = last_clamped;
          gap_len_d = bus.gap;
        end
      end
      // stop is only honoured together with a handshake so valid never drops unaccepted.
      ST_SEND: begin
        if (hs) begin
          if (bus.stop) begin
            state_d = ST_IDLE;
          end else if ((idx_q == last_q) && !loop_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d = (idx_q == last_q) ? '0 : idx_q + 1'b1;
            if (gap_len_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_len_q;
            end
          end
        end
      end
      ST_GAP: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they are registered yet cycle-accurate.
  always_comb begin
    out_valid_d = (state_d == ST_SEND);
    out_x_d     = out_valid_d ? rd_data : '0;
    out_idx_d   = out_valid_d ? idx_d : '0;
    out_last_d  = out_valid_d && (idx_d == last_d);
    en_d        = (state_d == ST_SEND) || (state_d == ST_GAP);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      gap_len_q   <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_len_q   <= gap_len_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      en_q        <= en_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_x_flat = out_x_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_last   = out_last_q;
  assign bus.en         = en_q;
  assign bus.busy       = en_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_softmax_stim_seq.sv
// Self-checking bench for softmax_stim_seq: directed scenarios plus a per-cycle stream checker
// driven by an expected-handshake queue and a mirror of the vector store contents.
module tb_softmax_stim_seq;

  localparam int N     = 64;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int GAP_W = 4;
  localparam int AW    = 2;
  localparam int VW    = N * W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  softmax_stim_seq_if #(.N(N), .W(W), .DEPTH(DEPTH), .GAP_W(GAP_W)) bus ();

  softmax_stim_seq #(.N(N), .W(W), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] model_mem [DEPTH];
  int  exp_q[$];
  int  exp_last;
  int  exp_gap;
  bit  cmp_on;
  bit  track_prev;
  int  low_cnt;
  logic prev_valid;

  // Element e of stored vector v is v*0x100 + 3*e + 1.
  function automatic logic [VW-1:0] make_vec(input int v);
    logic [VW-1:0] r;
    r = '0;
    for (int e = 0; e < N; e++) r[e*W +: W] = 16'(v * 256 + e * 3 + 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int e = 0; e < N; e++) begin
        if (act[e*W +: W] !== exp[e*W +: W]) begin
          $display("[TB] FAIL %s: element %0d got %h expected %h at %0t",
                   name, e, act[e*W +: W], exp[e*W +: W], $time);
          break;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic lp,
                               input logic [AW-1:0] last, input logic [GAP_W-1:0] g,
                               input logic rdy);
    bus.start     = st;
    bus.stop      = sp;
    bus.mode_loop = lp;
    bus.last_idx  = last;
    bus.gap       = g;
    bus.out_ready = rdy;
  endtask

  task automatic setWrite(input logic we, input logic [AW-1:0] addr, input logic [VW-1:0] data);
    bus.wr_en   = we;
    bus.wr_addr = addr;
    bus.wr_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitQueueEmpty(input int bound);
    int n;
    for (n = 0; n < bound; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Stream checker: payload/last against the store mirror, zeroed outputs while invalid,
  // handshake order against exp_q, and the idle-cycle count between handshakes.
  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("busy_eq_en", 64'(bus.busy), 64'(bus.en));
      if (bus.out_valid) begin
        checkVec("payload", bus.out_x_flat, model_mem[bus.out_idx]);
        checkOutput("out_last", 64'(bus.out_last), 64'(int'(bus.out_idx) == exp_last));
      end else begin
        checkOutput("idle_payload_zero", 64'(bus.out_x_flat != '0), 64'd0);
        checkOutput("idle_idx_zero", 64'(bus.out_idx), 64'd0);
        checkOutput("idle_last_zero", 64'(bus.out_last), 64'd0);
      end
      if (!bus.en) begin
        track_prev = 1'b0;
      end else if (bus.out_valid && !prev_valid && track_prev) begin
        checkOutput("gap_len", 64'(low_cnt), 64'(exp_gap));
      end
      if (!bus.out_valid) low_cnt++;
      if (bus.out_valid && bus.out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_hs: got idx %0d expected none at %0t", bus.out_idx, $time);
        end else begin
          checkOutput("hs_idx", 64'(bus.out_idx), 64'(exp_q.pop_front()));
        end
        track_prev = 1'b1;
        low_cnt    = 0;
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmp_on = 1'b0;
    exp_last = 0;
    exp_gap = 0;
    track_prev = 1'b0;
    low_cnt = 0;
    prev_valid = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    setWrite(0, 0, '0);
    tick();
    tick();

    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_en", 64'(bus.en), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_idx", 64'(bus.out_idx), 64'd0);
    checkOutput("rst_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_payload_zero", 64'(bus.out_x_flat != '0), 64'd0);
    rst = 1'b0;
    cmp_on = 1'b1;

    for (int v = 0; v < DEPTH; v++) begin
      model_mem[v] = make_vec(v);
      setWrite(1, AW'(v), model_mem[v]);
      tick();
    end
    setWrite(0, 0, '0);

    $display("[TB] single pass, last_idx=2");
    exp_last = 2;
    exp_q = {0, 1, 2};
    applyStimulus(1, 0, 0, 2'd2, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 2'd2, 0, 1);
    checkOutput("t1_valid0", 64'(bus.out_valid), 64'd1);
    checkOutput("t1_idx0", 64'(bus.out_idx), 64'd0);
    checkOutput("t1_v0e0", 64'(bus.out_x_flat[0 +: W]), 64'h0001);
    tick();
    checkOutput("t1_idx1", 64'(bus.out_idx), 64'd1);
    checkOutput("t1_last1", 64'(bus.out_last), 64'd0);
    tick();
    checkOutput("t1_idx2", 64'(bus.out_idx), 64'd2);
    checkOutput("t1_last2", 64'(bus.out_last), 64'd1);
    checkOutput("t1_v2e5", 64'(bus.out_x_flat[5*W +: W]), 64'h0210);
    tick();
    checkOutput("t1_done", 64'(bus.done), 64'd1);
    checkOutput("t1_en_off", 64'(bus.en), 64'd0);
    checkOutput("t1_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] backpressure on idx 1");
    exp_q = {0, 1, 2};
    applyStimulus(1, 0, 0, 2'd2, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 2'd2, 0, 0);
    checkOutput("t2_idx0", 64'(bus.out_idx), 64'd0);
    checkOutput("t2_done_clr", 64'(bus.done), 64'd0);
    applyStimulus(0, 0, 0, 2'd2, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 2'd2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t2_hold_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("t2_hold_idx", 64'(bus.out_idx), 64'd1);
      checkOutput("t2_hold_e0", 64'(bus.out_x_flat[0 +: W]), 64'h0101);
    end
    applyStimulus(0, 0, 0, 2'd2, 0, 1);
    tick();
    checkOutput("t2_idx2", 64'(bus.out_idx), 64'd2);
    tick();
    checkOutput("t2_done", 64'(bus.done), 64'd1);
    checkOutput("t2_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] loop with gap=3, then stop in GAP");
    exp_last = 1;
    exp_gap = 3;
    exp_q = {0, 1, 0, 1, 0};
    applyStimulus(1, 0, 1, 2'd1, 4'd3, 1);
    tick();
    applyStimulus(0, 0, 1, 2'd1, 4'd3, 1);
    checkOutput("t3_idx0", 64'(bus.out_idx), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_gap_low", 64'(bus.out_valid), 64'd0);
      checkOutput("t3_gap_en", 64'(bus.en), 64'd1);
      tick();
    end
    checkOutput("t3_resume_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("t3_resume_idx", 64'(bus.out_idx), 64'd1);
    waitQueueEmpty(60);
    checkOutput("t3_in_gap", 64'(bus.en & ~bus.out_valid), 64'd1);
    applyStimulus(0, 1, 1, 2'd1, 4'd3, 1);
    tick();
    applyStimulus(0, 0, 1, 2'd1, 4'd3, 1);
    checkOutput("t4a_en_off", 64'(bus.en), 64'd0);
    checkOutput("t4a_done", 64'(bus.done), 64'd0);

    $display("[TB] stop in SEND held by backpressure");
    exp_last = 3;
    exp_gap = 0;
    exp_q = {0};
    applyStimulus(1, 0, 1, 2'd3, 0, 0);
    tick();
    applyStimulus(0, 1, 1, 2'd3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t4b_hold_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("t4b_hold_idx", 64'(bus.out_idx), 64'd0);
    end
    applyStimulus(0, 1, 1, 2'd3, 0, 1);
    tick();
    applyStimulus(0, 0, 1, 2'd3, 0, 0);
    checkOutput("t4b_valid_off", 64'(bus.out_valid), 64'd0);
    checkOutput("t4b_en_off", 64'(bus.en), 64'd0);
    checkOutput("t4b_done", 64'(bus.done), 64'd0);
    checkOutput("t4b_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] load addr 3, clamp last_idx, write while busy");
    model_mem[3] = {N{16'h0100}};
    setWrite(1, 2'd3, model_mem[3]);
    tick();
    setWrite(0, 0, '0);
    exp_last = 3;
    exp_q = {0, 1, 2, 3};
    applyStimulus(1, 0, 0, AW'(7), 0, 1);
    tick();
    applyStimulus(0, 0, 0, AW'(7), 0, 1);
    setWrite(1, 2'd0, {VW{1'b1}});
    tick();
    setWrite(0, 0, '0);
    checkOutput("t5_idx1", 64'(bus.out_idx), 64'd1);
    tick();
    tick();
    checkOutput("t5_idx3", 64'(bus.out_idx), 64'd3);
    checkOutput("t5_last3", 64'(bus.out_last), 64'd1);
    checkOutput("t5_loaded_e0", 64'(bus.out_x_flat[0 +: W]), 64'h0100);
    tick();
    checkOutput("t5_done", 64'(bus.done), 64'd1);
    checkOutput("t5_queue", 64'(exp_q.size()), 64'd0);
    exp_last = 0;
    exp_q = {0};
    applyStimulus(1, 0, 0, 2'd0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 2'd0, 0, 1);
    checkOutput("t5_v0_kept", 64'(bus.out_x_flat[0 +: W]), 64'h0001);
    tick();
    checkOutput("t5_done2", 64'(bus.done), 64'd1);

    $display("[TB] reset mid-SEND, then replay");
    exp_last = 3;
    exp_q = {0};
    applyStimulus(1, 0, 1, 2'd3, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 2'd3, 0, 0);
    checkOutput("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("t6_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t6_en", 64'(bus.en), 64'd0);
    checkOutput("t6_done", 64'(bus.done), 64'd0);
    checkOutput("t6_payload_zero", 64'(bus.out_x_flat != '0), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_last = 1;
    exp_q = {0, 1};
    applyStimulus(1, 0, 0, 2'd1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 2'd1, 0, 1);
    checkOutput("t6_replay_idx0", 64'(bus.out_idx), 64'd0);
    tick();
    checkOutput("t6_replay_idx1", 64'(bus.out_idx), 64'd1);
    tick();
    checkOutput("t6_replay_done", 64'(bus.done), 64'd1);
    checkOutput("t6_queue", 64'(exp_q.size()), 64'd0);

    tick();
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
